dual_axis_tx: RTL and testbench
===============================

DUAL_AXIS_TX -- requirements
Module: dual_axis_tx

Interface
REQ-001 Parameter A_WL, default 16: lane A sample width in bits, signed.
REQ-002 Parameter B_WL, default 16: lane B sample width in bits, signed.
REQ-003 aclk  input  1  sole clock; all state updates on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 s_tdata  input  A_WL+B_WL  packed pair; [A_WL-1:0] = A sample, [A_WL+B_WL-1:A_WL] = B sample.
REQ-006 s_tvalid  input  1  upstream pair valid.
REQ-007 s_tready  output  1  block can accept a pair this cycle.
REQ-008 a_tdata  output  A_WL (signed)  lane A sample to downstream consumer.
REQ-009 a_tvalid  output  1  lane A sample valid.
REQ-010 a_tready  input  1  lane A consumer ready.
REQ-011 b_tdata  output  B_WL (signed)  lane B sample.
REQ-012 b_tvalid  output  1  lane B sample valid.
REQ-013 b_tready  input  1  lane B consumer ready.
REQ-014 pair_cnt  output  16  count of accepted input pairs, wraps 0xFFFF->0x0000.

Function
REQ-015 Input transfer occurs when s_tvalid && s_tready at a rising edge; A half pushes into lane-A buffer, B half into lane-B buffer, same edge.
REQ-016 Each lane has an independent 2-entry FIFO with occupancy count 0..2.
REQ-017 s_tready SHALL equal (a_cnt<2) && (b_cnt<2), derived from registered counts only; no combinational path from a_tready/b_tready to s_tready.
REQ-018 Push into a full lane (count==2) never occurs; a same-cycle pop does not enable a push when count==2.
REQ-019 Lane output transfer occurs when x_tvalid && x_tready; x_tvalid SHALL equal (x_cnt!=0); x_tdata presents the oldest entry.
REQ-020 Latency: a pair accepted at edge N into an empty lane appears on x_tdata/x_tvalid after edge N (1 cycle), no bypass.
REQ-021 Simultaneous push and pop on a lane with count 1: count stays 1, head becomes pushed sample after the edge.
REQ-022 Simultaneous push and pop on a lane with count 0 is impossible (x_tvalid=0), count becomes 1.
REQ-023 Lanes drain independently; lane A may run up to 2 samples ahead of or behind lane B; data order within each lane strictly preserved.
REQ-024 While x_tvalid=1 and x_tready=0, x_tdata SHALL remain stable.
REQ-025 pair_cnt increments by 1 on each input transfer, modulo 2^16.
REQ-026 Sample bits pass unmodified; no sign extension, truncation or arithmetic.

Reset
REQ-027 aresetn low SHALL immediately clear a_cnt, b_cnt, pointers and pair_cnt, independent of aclk.
REQ-028 During reset: a_tvalid=0, b_tvalid=0, s_tready=0, pair_cnt=0; a_tdata/b_tdata=0.
REQ-029 s_tready SHALL assert on the first rising edge after aresetn deasserts; no input accepted on that edge.
REQ-030 Reset mid-operation discards all buffered samples; no partial pair is emitted afterwards.

Verification
REQ-031 Both readies high, s_tdata=0x8001_7FFF valid one cycle -> next cycle a_tdata=0x7FFF, b_tdata=0x8001, both valid one cycle; pair_cnt=1.
REQ-032 a_tready=0, b_tready=1, 4 pairs offered back-to-back -> 2 accepted, s_tready drops after 2nd; lane B emits 2 samples; lane A holds first sample stable.
REQ-033 Release a_tready after REQ-032 stall -> lane A emits samples 1,2 in order; s_tready returns high next cycle; remaining pairs accepted in order.
REQ-034 Random a_tready/b_tready/s_tvalid, 10000 pairs, A_WL=16, B_WL=32 -> scoreboard per lane matches input order, no loss/duplication.
REQ-035 Preload pair_cnt to 0xFFFF via 65535 transfers, one more transfer -> pair_cnt=0x0000.
REQ-036 Assert aresetn low with both lanes holding 2 samples -> a_tvalid/b_tvalid/s_tready/pair_cnt drop to 0 before next aclk edge; after release, no stale sample emitted.

Source files
------------

// File: rtl/dual_axis_tx.sv
// -----------------------------------------------------------------------------
// dual_axis_tx
// Splits a stream of packed {B, A} sample pairs into two independent
// AXI-Stream-style output lanes. Each lane has its own 2-entry FIFO, so one
// lane may stall while the other keeps draining. A new pair is accepted only
// when both lanes have room.
//
// Ports
//   aclk      : clock, all state changes on the rising edge
//   aresetn   : asynchronous active-low reset
//   s_tdata   : input pair, [A_WL-1:0] = A sample, [A_WL+B_WL-1:A_WL] = B sample
//   s_tvalid  : input pair valid
//   s_tready  : block can accept a pair this cycle (registered state only)
//   a_tdata   : lane A oldest sample
//   a_tvalid  : lane A holds at least one sample
//   a_tready  : lane A consumer ready
//   b_tdata   : lane B oldest sample
//   b_tvalid  : lane B holds at least one sample
//   b_tready  : lane B consumer ready
//   pair_cnt  : number of accepted pairs, modulo 2^16
// -----------------------------------------------------------------------------
module dual_axis_tx #(
    parameter int A_WL = 16,
    parameter int B_WL = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [A_WL+B_WL-1:0]     s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic signed [A_WL-1:0]   a_tdata,
    output logic                     a_tvalid,
    input  logic                     a_tready,
    output logic signed [B_WL-1:0]   b_tdata,
    output logic                     b_tvalid,
    input  logic                     b_tready,
    output logic [15:0]              pair_cnt
);

    // Held low through reset and for the first edge after it, so the block
    // never accepts a pair on the edge where reset is released.
    logic            ready_en_r;

    logic [A_WL-1:0] a_mem_r [0:1];
    logic            a_wr_ptr_r;
    logic            a_rd_ptr_r;
    logic [1:0]      a_cnt_r;
    logic [1:0]      a_cnt_nxt_s;

    logic [B_WL-1:0] b_mem_r [0:1];
    logic            b_wr_ptr_r;
    logic            b_rd_ptr_r;
    logic [1:0]      b_cnt_r;
    logic [1:0]      b_cnt_nxt_s;

    logic [15:0]     pair_cnt_r;

    logic            push_s;
    logic            a_pop_s;
    logic            b_pop_s;

    // Readiness depends only on registered counts: a same-cycle pop on a full
    // lane deliberately does not open the input.
    assign s_tready = ready_en_r && (a_cnt_r < 2'd2) && (b_cnt_r < 2'd2);
    assign push_s   = s_tvalid && s_tready;

    assign a_tvalid = (a_cnt_r != 2'd0);
    assign b_tvalid = (b_cnt_r != 2'd0);
    assign a_pop_s  = a_tvalid && a_tready;
    assign b_pop_s  = b_tvalid && b_tready;

    // Head entry is presented straight from storage; it cannot change while
    // the lane is stalled because only a pop moves the read pointer.
    assign a_tdata  = a_mem_r[a_rd_ptr_r];
    assign b_tdata  = b_mem_r[b_rd_ptr_r];
    assign pair_cnt = pair_cnt_r;

    // Input-enable flag: opens one edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Lane A occupancy next-state from the push/pop pair.
    always_comb begin
        a_cnt_nxt_s = a_cnt_r;
        case ({push_s, a_pop_s})
            2'b10:   a_cnt_nxt_s = a_cnt_r + 2'd1;
            2'b01:   a_cnt_nxt_s = a_cnt_r - 2'd1;
            default: a_cnt_nxt_s = a_cnt_r;
        endcase
    end

    // Lane B occupancy next-state from the push/pop pair.
    always_comb begin
        b_cnt_nxt_s = b_cnt_r;
        case ({push_s, b_pop_s})
            2'b10:   b_cnt_nxt_s = b_cnt_r + 2'd1;
            2'b01:   b_cnt_nxt_s = b_cnt_r - 2'd1;
            default: b_cnt_nxt_s = b_cnt_r;
        endcase
    end

    // Lane A storage, pointers and count; storage is cleared so the data
    // outputs read zero during reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_mem_r[0] <= {A_WL{1'b0}};
            a_mem_r[1] <= {A_WL{1'b0}};
            a_wr_ptr_r <= 1'b0;
            a_rd_ptr_r <= 1'b0;
            a_cnt_r    <= 2'd0;
        end else begin
            if (push_s) begin
                a_mem_r[a_wr_ptr_r] <= s_tdata[A_WL-1:0];
                a_wr_ptr_r          <= ~a_wr_ptr_r;
            end
            if (a_pop_s) begin
                a_rd_ptr_r <= ~a_rd_ptr_r;
            end
            a_cnt_r <= a_cnt_nxt_s;
        end
    end

    // Lane B storage, pointers and count.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            b_mem_r[0] <= {B_WL{1'b0}};
            b_mem_r[1] <= {B_WL{1'b0}};
            b_wr_ptr_r <= 1'b0;
            b_rd_ptr_r <= 1'b0;
            b_cnt_r    <= 2'd0;
        end else begin
            if (push_s) begin
                b_mem_r[b_wr_ptr_r] <= s_tdata[A_WL+B_WL-1:A_WL];
                b_wr_ptr_r          <= ~b_wr_ptr_r;
            end
            if (b_pop_s) begin
                b_rd_ptr_r <= ~b_rd_ptr_r;
            end
            b_cnt_r <= b_cnt_nxt_s;
        end
    end

    // Accepted-pair counter, wraps naturally at 16 bits.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pair_cnt_r <= 16'd0;
        end else if (push_s) begin
            pair_cnt_r <= pair_cnt_r + 16'd1;
        end else begin
            pair_cnt_r <= pair_cnt_r;
        end
    end

endmodule

// File: tb/tb_dual_axis_tx.sv
// -----------------------------------------------------------------------------
// tb_dual_axis_tx
// Directed table of per-cycle vectors for the reset/latency/stall sequences,
// followed by queue-model driven steps for random traffic, counter wrap and
// mid-operation reset. Outputs are compared on the falling edge; inputs are
// driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_dual_axis_tx;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] a_tdata;
    logic        a_tvalid;
    logic        a_tready;
    logic [15:0] b_tdata;
    logic        b_tvalid;
    logic        b_tready;
    logic [15:0] pair_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] m_pc;
    logic        m_en;

    dual_axis_tx #(.A_WL(16), .B_WL(16)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .a_tdata  (a_tdata),
        .a_tvalid (a_tvalid),
        .a_tready (a_tready),
        .b_tdata  (b_tdata),
        .b_tvalid (b_tvalid),
        .b_tready (b_tready),
        .pair_cnt (pair_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] din;
        logic        vld;
        logic        ardy;
        logic        brdy;
        logic        e_rdy;
        logic        e_av;
        logic [15:0] e_ad;
        logic        e_bv;
        logic [15:0] e_bd;
        logic [15:0] e_pc;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle against the queue model: compare, drive, advance model.
    task automatic step(input logic [31:0] din, input logic vld, input logic ardy, input logic brdy);
        logic exp_rdy;
        exp_rdy = m_en && (qa.size() < 2) && (qb.size() < 2);
        chk("s_tready", {31'd0, s_tready}, {31'd0, exp_rdy});
        chk("a_tvalid", {31'd0, a_tvalid}, {31'd0, qa.size() != 0});
        chk("b_tvalid", {31'd0, b_tvalid}, {31'd0, qb.size() != 0});
        if (qa.size() != 0) chk("a_tdata", {16'd0, a_tdata}, {16'd0, qa[0]});
        if (qb.size() != 0) chk("b_tdata", {16'd0, b_tdata}, {16'd0, qb[0]});
        chk("pair_cnt", {16'd0, pair_cnt}, {16'd0, m_pc});
        s_tdata  = din;
        s_tvalid = vld;
        a_tready = ardy;
        b_tready = brdy;
        if (ardy && (qa.size() != 0)) void'(qa.pop_front());
        if (brdy && (qb.size() != 0)) void'(qb.pop_front());
        if (vld && exp_rdy) begin
            qa.push_back(din[15:0]);
            qb.push_back(din[31:16]);
            m_pc = m_pc + 16'd1;
        end
        m_en = 1'b1;
        @(negedge aclk);
    endtask

    initial begin
        //        din           vld   ardy  brdy  rdy   av    ad       bv    bd       pc
        tbl[0]  = '{32'h8001_7FFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0};
        tbl[1]  = '{32'h8001_7FFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0};
        tbl[2]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1, 16'h8001, 16'd1};
        tbl[3]  = '{32'hB001_A001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd1};
        tbl[4]  = '{32'hB002_A002, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA001, 1'b1, 16'hB001, 16'd2};
        tbl[5]  = '{32'hB003_A003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA001, 1'b1, 16'hB002, 16'd3};
        tbl[6]  = '{32'hB003_A003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA001, 1'b0, 16'h0000, 16'd3};
        tbl[7]  = '{32'hB003_A003, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA001, 1'b0, 16'h0000, 16'd3};
        tbl[8]  = '{32'hB003_A003, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA002, 1'b0, 16'h0000, 16'd3};
        tbl[9]  = '{32'hB004_A004, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA003, 1'b1, 16'hB003, 16'd4};
        tbl[10] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA004, 1'b1, 16'hB004, 16'd5};
        tbl[11] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd5};

        aresetn  = 1'b0;
        s_tdata  = 32'd0;
        s_tvalid = 1'b0;
        a_tready = 1'b0;
        b_tready = 1'b0;
        m_pc     = 16'd0;
        m_en     = 1'b0;

        // Reset state
        repeat (2) @(negedge aclk);
        chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
        chk("rst_a_tvalid", {31'd0, a_tvalid}, 32'd0);
        chk("rst_b_tvalid", {31'd0, b_tvalid}, 32'd0);
        chk("rst_pair_cnt", {16'd0, pair_cnt}, 32'd0);
        chk("rst_a_tdata",  {16'd0, a_tdata},  32'd0);
        chk("rst_b_tdata",  {16'd0, b_tdata},  32'd0);
        aresetn = 1'b1;

        // Directed table: first edge after reset, latency, lane-A stall/release
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("v%0d_s_tready", i), {31'd0, s_tready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("v%0d_a_tvalid", i), {31'd0, a_tvalid}, {31'd0, tbl[i].e_av});
            chk($sformatf("v%0d_b_tvalid", i), {31'd0, b_tvalid}, {31'd0, tbl[i].e_bv});
            if (tbl[i].e_av) chk($sformatf("v%0d_a_tdata", i), {16'd0, a_tdata}, {16'd0, tbl[i].e_ad});
            if (tbl[i].e_bv) chk($sformatf("v%0d_b_tdata", i), {16'd0, b_tdata}, {16'd0, tbl[i].e_bd});
            chk($sformatf("v%0d_pair_cnt", i), {16'd0, pair_cnt}, {16'd0, tbl[i].e_pc});
            s_tdata  = tbl[i].din;
            s_tvalid = tbl[i].vld;
            a_tready = tbl[i].ardy;
            b_tready = tbl[i].brdy;
            @(negedge aclk);
        end

        // Hand off to the queue model: lanes empty, five pairs accepted
        m_pc = 16'd5;
        m_en = 1'b1;

        // Random traffic with independent lane stalls
        for (int i = 0; i < 600; i++) begin
            step($urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        end
        repeat (3) step(32'd0, 1'b0, 1'b1, 1'b1);

        // Counter wrap: bring pair_cnt to 0xFFFF, then one more transfer
        begin
            int n;
            n = 32'hFFFF - {16'd0, m_pc};
            for (int i = 0; i < n; i++) begin
                step(i, 1'b1, 1'b1, 1'b1);
            end
        end
        chk("pair_cnt_ffff", {16'd0, pair_cnt}, 32'h0000_FFFF);
        step(32'h1234_5678, 1'b1, 1'b1, 1'b1);
        chk("pair_cnt_wrap", {16'd0, pair_cnt}, 32'h0000_0000);

        // Fill both lanes to two entries, then reset mid-operation
        repeat (2) step(32'd0, 1'b0, 1'b1, 1'b1);
        step(32'hC001_D001, 1'b1, 1'b0, 1'b0);
        step(32'hC002_D002, 1'b1, 1'b0, 1'b0);
        step(32'd0, 1'b0, 1'b0, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_a_tvalid", {31'd0, a_tvalid}, 32'd0);
        chk("arst_b_tvalid", {31'd0, b_tvalid}, 32'd0);
        chk("arst_s_tready", {31'd0, s_tready}, 32'd0);
        chk("arst_pair_cnt", {16'd0, pair_cnt}, 32'd0);
        chk("arst_a_tdata",  {16'd0, a_tdata},  32'd0);
        chk("arst_b_tdata",  {16'd0, b_tdata},  32'd0);
        qa.delete();
        qb.delete();
        m_pc = 16'd0;
        m_en = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;

        // No stale samples after release; fresh traffic still flows
        repeat (3) step(32'd0, 1'b0, 1'b1, 1'b1);
        step(32'hE00E_F00F, 1'b1, 1'b1, 1'b1);
        repeat (2) step(32'd0, 1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
